spdif_in: RTL and testbench

- S/PDIF (IEC 60958) receiver; the receive-side counterpart of spdif_out.
- Oversamples an asynchronous biphase-mark stream on the ~98.304 MHz clock and recovers frame timing from edge intervals.
- Decodes left/right 24-bit samples and presents one stereo pair per frame with a single-cycle valid strobe.
- Feeds the mixer input path alongside adat_in.

---
 rtl/spdif_pkg.sv | 21 ++
 rtl/spdif_pulse_classifier.sv | 57 +++++
 rtl/spdif_in.sv | 146 ++++++++++++++
 tb/tb_spdif_in.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spdif_pkg.sv
// spdif_pkg: shared types and slot constants for the S/PDIF receiver.
//   interval_t : edge-interval class produced by the pulse classifier
//   preamble_t : decoded subframe preamble
//   state_t    : subframe framing FSM states
package spdif_pkg;
  typedef enum logic [1:0] {SHORT, LONG, XLONG, BAD} interval_t;
  typedef enum logic [1:0] {PRE_B, PRE_M, PRE_W, PRE_NONE} preamble_t;
  typedef enum logic [2:0] {HUNT, PRE1, PRE2, PRE3, DATA} state_t;
  localparam int AUDIO_FIRST = 4;
  localparam int AUDIO_LAST = 27;
  localparam int SLOT_V = 28;
  localparam int SLOT_P = 31;
  localparam int AUDIO_BITS = AUDIO_LAST - AUDIO_FIRST + 1;
  // The leading XLONG is implied by entering PRE1, so only the remaining three
  // interval classes distinguish the preambles.
  function automatic preamble_t decode_pre(interval_t a, interval_t b, interval_t c);
    return (a == SHORT && b == SHORT && c == XLONG) ? PRE_B :
           (a == XLONG && b == SHORT && c == SHORT) ? PRE_M :
           (a == LONG  && b == SHORT && c == LONG)  ? PRE_W : PRE_NONE;
  endfunction
endpackage

// File: rtl/spdif_pulse_classifier.sv
// spdif_pulse_classifier: synchronises the raw line, measures edge-to-edge intervals
// and classifies them in units of the biphase half-cell.
//   clk, rst        : clock, asynchronous active-high reset
//   spdif_async     : raw S/PDIF line
//   interval        : class of the interval that just ended (valid with interval_done)
//   interval_done   : one-cycle strobe per detected edge
//   timeout         : one-cycle strobe when the line stays static too long
module spdif_pulse_classifier import spdif_pkg::*; #(
  parameter int CLKS_PER_UI = 16,
  parameter int TIMEOUT_UI = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      spdif_async,
  output interval_t interval,
  output logic      interval_done,
  output logic      timeout
);
  localparam int U = CLKS_PER_UI;
  // The counter saturates at 63, so the timeout threshold cannot exceed that.
  localparam int TO_N = (TIMEOUT_UI * U > 63) ? 63 : TIMEOUT_UI * U;
  logic [2:0] sync;
  logic [5:0] cnt;
  logic fired, edge_hit, to_hit;
  assign edge_hit = sync[2] ^ sync[1];
  // fired keeps a static line from re-reporting the timeout every cycle
  assign to_hit = !edge_hit && !fired && int'(cnt) >= TO_N - 1;
  function automatic interval_t classify(logic [5:0] n);
    int d;
    d = 2 * int'(n);
    return (d >= U && d < 3 * U)     ? SHORT :
           (d >= 3 * U && d < 5 * U) ? LONG  :
           (d >= 5 * U && d < 7 * U) ? XLONG : BAD;
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      fired <= 1'b0;
      interval <= BAD;
      interval_done <= 1'b0;
      timeout <= 1'b0;
    end else begin
      sync <= {sync[1:0], spdif_async};
      interval_done <= edge_hit;
      timeout <= to_hit;
      if (edge_hit) begin
        cnt <= 6'd1;
        fired <= 1'b0;
        interval <= classify(cnt);
      end else begin
        cnt <= (cnt == 6'd63) ? cnt : cnt + 6'd1;
        fired <= fired | to_hit;
      end
    end
  end
endmodule

// File: rtl/spdif_in.sv
// spdif_in: S/PDIF (IEC 60958) receiver producing one stereo 24-bit pair per frame.
//   clk, rst      : oversampling clock, asynchronous active-high reset
//   spdif_async   : raw biphase-mark line
//   ldataout      : left sample of the last accepted frame
//   rdataout      : right sample of the last accepted frame
//   data_valid    : one-cycle strobe with each new pair
//   block_start   : presented frame began with preamble B
//   lock          : LOCK_FRAMES consecutive good frames since the last error
//   parity_error  : one-cycle strobe on a subframe parity failure
module spdif_in import spdif_pkg::*; #(
  parameter int CLKS_PER_UI = 16,
  parameter int LOCK_FRAMES = 4,
  parameter int TIMEOUT_UI = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spdif_async,
  output logic [23:0] ldataout,
  output logic [23:0] rdataout,
  output logic        data_valid,
  output logic        block_start,
  output logic        lock,
  output logic        parity_error
);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  interval_t iv, c1, c2;
  preamble_t pre, pre_dec;
  state_t state, state_n;
  logic done, to, half, half_n, bit_ok, bit_val, err, sub_done, par, left_ok, is_b;
  logic [5:0] slot;
  logic [AUDIO_BITS-1:0] sr, lhold;
  logic [GW-1:0] good_cnt, good_n;

  spdif_pulse_classifier #(.CLKS_PER_UI(CLKS_PER_UI), .TIMEOUT_UI(TIMEOUT_UI)) u_cls (
    .clk(clk),
    .rst(rst),
    .spdif_async(spdif_async),
    .interval(iv),
    .interval_done(done),
    .timeout(to)
  );

  assign pre_dec = decode_pre(c1, c2, iv);
  assign good_n = (good_cnt == GW'(LOCK_FRAMES)) ? good_cnt : good_cnt + GW'(1);
  assign sub_done = bit_ok && slot == 6'(SLOT_P);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else state <= state_n;
  end

  // Slot 32 means "subframe complete": the next interval must be the XLONG
  // that opens the following preamble.
  always_comb begin
    state_n = state;
    half_n = half;
    bit_ok = 1'b0;
    bit_val = 1'b0;
    err = to;
    if (!to && done)
      case (state)
        HUNT: state_n = (iv == XLONG) ? PRE1 : HUNT;
        PRE1: state_n = PRE2;
        PRE2: state_n = PRE3;
        PRE3: begin
          state_n = DATA;
          err = (pre_dec == PRE_NONE);
        end
        default:
          if (slot == 6'(SLOT_P + 1)) begin
            state_n = PRE1;
            err = (iv != XLONG);
          end else if (iv == SHORT) begin
            half_n = !half;
            bit_ok = half;
            bit_val = 1'b1;
          end else if (iv == LONG && !half) bit_ok = 1'b1;
          else err = 1'b1;
      endcase
    if (err) state_n = HUNT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c1 <= SHORT;
      c2 <= SHORT;
      pre <= PRE_NONE;
      slot <= '0;
      half <= 1'b0;
      par <= 1'b0;
      sr <= '0;
      lhold <= '0;
      left_ok <= 1'b0;
      is_b <= 1'b0;
      good_cnt <= '0;
      ldataout <= '0;
      rdataout <= '0;
      data_valid <= 1'b0;
      block_start <= 1'b0;
      lock <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_error <= 1'b0;
      half <= half_n;
      if (done && state == PRE1) c1 <= iv;
      if (done && state == PRE2) c2 <= iv;
      if (bit_ok) begin
        slot <= slot + 6'd1;
        par <= par ^ bit_val;
        if (slot < 6'(SLOT_V)) sr <= {bit_val, sr[AUDIO_BITS-1:1]};
      end
      if (state == PRE3 && state_n == DATA) begin
        pre <= pre_dec;
        slot <= 6'(AUDIO_FIRST);
        half <= 1'b0;
        par <= 1'b0;
      end
      // A parity failure drops the subframe and any pending left half, but
      // leaves framing and lock untouched.
      if (sub_done) begin
        if (par ^ bit_val) begin
          parity_error <= 1'b1;
          left_ok <= 1'b0;
        end else if (pre != PRE_W) begin
          lhold <= sr;
          left_ok <= 1'b1;
          is_b <= (pre == PRE_B);
        end else if (left_ok) begin
          ldataout <= lhold;
          rdataout <= sr;
          block_start <= is_b;
          data_valid <= 1'b1;
          left_ok <= 1'b0;
          good_cnt <= good_n;
          lock <= (good_n == GW'(LOCK_FRAMES));
        end
      end
      if (err) begin
        left_ok <= 1'b0;
        lock <= 1'b0;
        good_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_spdif_in.sv
// tb_spdif_in: randomized self-checking bench for spdif_in, driving biphase-mark
// frames built from the line-coding rules and comparing decoded pairs to a frame-level model.
module tb_spdif_in;
  localparam int U = 16;
  localparam int LK = 4;
  typedef struct packed {logic [23:0] l; logic [23:0] r; logic bs; logic lk;} ev_t;
  logic clk = 1'b0, rst = 1'b1, line = 1'b0;
  logic [23:0] ldataout, rdataout;
  logic data_valid, block_start, lock, parity_error;
  ev_t obs_q[$], exp_q[$];
  int checks = 0, errors = 0, perr_cnt = 0, m_good = 0;
  logic perr_lock = 1'b0;
  bit jit = 1'b0;

  spdif_in #(.CLKS_PER_UI(U), .LOCK_FRAMES(LK), .TIMEOUT_UI(4)) dut (
    .clk(clk),
    .rst(rst),
    .spdif_async(line),
    .ldataout(ldataout),
    .rdataout(rdataout),
    .data_valid(data_valid),
    .block_start(block_start),
    .lock(lock),
    .parity_error(parity_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) obs_q.push_back({ldataout, rdataout, block_start, lock});
    if (parity_error) begin
      perr_cnt++;
      perr_lock = lock;
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lead_in();
    @(negedge clk);
    line = ~line;
  endtask

  // One interval of 'units' half-cells, optionally jittered by +-7 clocks.
  task automatic ivl(int units);
    int n;
    n = units * U + (jit ? int'($urandom_range(14)) - 7 : 0);
    repeat (n) @(negedge clk);
    line = ~line;
  endtask

  // kind: 0=B, 1=M, 2=W, other=illegal preamble (X,S,L,L)
  task automatic send_sub(int kind, logic [23:0] d, bit badp);
    logic [31:0] w;
    w = '0;
    w[27:4] = d;
    w[30] = 1'($urandom);
    w[31] = (^w[30:4]) ^ badp;
    case (kind)
      0: begin ivl(3); ivl(1); ivl(1); ivl(3); end
      1: begin ivl(3); ivl(3); ivl(1); ivl(1); end
      2: begin ivl(3); ivl(2); ivl(1); ivl(2); end
      default: begin ivl(3); ivl(1); ivl(2); ivl(2); end
    endcase
    for (int s = 4; s < 32; s++)
      if (w[s]) begin ivl(1); ivl(1); end
      else ivl(2);
  endtask

  task automatic send_frame(logic [23:0] l, logic [23:0] r, bit b, bit badr, bit expv);
    send_sub(b ? 0 : 1, l, 1'b0);
    send_sub(2, r, badr);
    if (expv) begin
      m_good++;
      exp_q.push_back({l, r, b, m_good >= LK});
    end
  endtask

  task automatic start_test();
    obs_q.delete();
    exp_q.delete();
    m_good = 0;
  endtask

  task automatic test_reset();
    idle(3);
    checks++;
    if ({ldataout, rdataout} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {ldataout, rdataout});
    end
    checks++;
    if ({data_valid, block_start, lock, parity_error} !== 4'h0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", {data_valid, block_start, lock, parity_error});
    end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_clean();
    start_test();
    jit = 1'b0;
    lead_in();
    for (int f = 0; f < 5; f++) send_frame(24'h123456, 24'hFEDCBA, f == 0, 1'b0, 1'b1);
    idle(100);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL clean_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL clean_ev%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_jitter();
    int p0;
    start_test();
    p0 = perr_cnt;
    jit = 1'b1;
    lead_in();
    for (int f = 0; f < 5; f++) send_frame(24'($urandom), 24'($urandom), $urandom_range(3) == 0, 1'b0, 1'b1);
    jit = 1'b0;
    idle(100);
    checks++;
    if (perr_cnt != p0) begin
      errors++;
      $display("FAIL jitter_parity: got %0d pulses want 0", perr_cnt - p0);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL jitter_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL jitter_ev%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_parity();
    int p0;
    start_test();
    p0 = perr_cnt;
    lead_in();
    for (int f = 0; f < 4; f++) send_frame(24'($urandom), 24'($urandom), f == 0, 1'b0, 1'b1);
    send_frame(24'($urandom), 24'($urandom), 1'b0, 1'b1, 1'b0);
    send_frame(24'($urandom), 24'($urandom), 1'b0, 1'b0, 1'b1);
    idle(100);
    checks++;
    if (perr_cnt != p0 + 1) begin
      errors++;
      $display("FAIL parity_pulses: got %0d want 1", perr_cnt - p0);
    end
    checks++;
    if (perr_lock !== 1'b1) begin
      errors++;
      $display("FAIL parity_lock: got %b want 1", perr_lock);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL parity_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL parity_ev%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [23:0] l, r;
    start_test();
    lead_in();
    for (int f = 0; f < 4; f++) begin
      l = 24'($urandom);
      r = 24'($urandom);
      send_frame(l, r, f == 0, 1'b0, 1'b1);
    end
    ivl(3); ivl(3); ivl(1); ivl(1);
    for (int b = 0; b < 5; b++) ivl(2);
    idle(80);
    checks++;
    if (lock !== 1'b0) begin
      errors++;
      $display("FAIL timeout_lock: got %b want 0", lock);
    end
    checks++;
    if ({ldataout, rdataout} !== {l, r}) begin
      errors++;
      $display("FAIL timeout_hold: got %h want %h", {ldataout, rdataout}, {l, r});
    end
    m_good = 0;
    lead_in();
    for (int f = 0; f < 4; f++) send_frame(24'($urandom), 24'($urandom), f == 2, 1'b0, 1'b1);
    idle(100);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL timeout_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL timeout_ev%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_bad_preamble();
    start_test();
    lead_in();
    for (int f = 0; f < 4; f++) send_frame(24'($urandom), 24'($urandom), f == 1, 1'b0, 1'b1);
    send_sub(3, 24'($urandom), 1'b0);
    send_sub(2, 24'($urandom), 1'b0);
    m_good = 0;
    for (int f = 0; f < 2; f++) send_frame(24'($urandom), 24'($urandom), f == 0, 1'b0, 1'b1);
    idle(100);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL badpre_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL badpre_ev%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    start_test();
    fork
      begin
        lead_in();
        send_frame(24'($urandom), 24'($urandom), 1'b1, 1'b0, 1'b0);
        for (int f = 0; f < 2; f++) send_frame(24'($urandom), 24'($urandom), f == 1, 1'b0, 1'b1);
      end
      begin
        idle(300);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ldataout, rdataout, data_valid, block_start, lock, parity_error} !== 52'h0) begin
          errors++;
          $display("FAIL rstmid_async: got %h want 0",
                   {ldataout, rdataout, data_valid, block_start, lock, parity_error});
        end
        idle(3);
        rst = 1'b0;
      end
    join
    idle(100);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rstmid_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rstmid_ev%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_jitter();
    test_parity();
    test_timeout();
    test_bad_preamble();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
